// File: rtl/lc4_wb_stage.sv
// lc4_wb_stage: writeback stage with flags, register write, redirect and post-redirect squash
module lc4_wb_stage #(
   parameter int WORD_SIZE = 256,
   parameter int INSN      = 19,
   parameter int IADDR     = 10,
   parameter int FLUSH_CNT = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_valid,
   input  logic                 i_stall,
   input  logic [INSN:0]        i_insn,
   input  logic [WORD_SIZE-1:0] i_r1data,
   input  logic [WORD_SIZE-1:0] i_result,
   output logic                 o_carry,
   output logic [2:0]           o_nzp,
   output logic                 o_we,
   output logic [3:0]           o_wsel,
   output logic [WORD_SIZE-1:0] o_wdata,
   output logic                 o_br_taken,
   output logic [IADDR:0]       o_br_target,
   output logic                 o_illegal
);
   typedef enum logic {RUN, FLUSH} state_t;
   state_t state, state_n;
   logic [2:0] cnt, cnt_n;
   logic [4:0] op;
   logic [3:0] rd;
   logic acc, run_acc, wr, tk, ill, n, z;
   logic [IADDR:0] tgt;
   assign op = i_insn[INSN -: 5];
   assign rd = i_insn[INSN-5 -: 4];
   assign acc = i_valid & ~i_stall;
   assign run_acc = acc & (state == RUN);
   assign n = i_result[WORD_SIZE-1];
   assign z = ~|i_result;
   // decode the opcode and compute the next squash state
   always_comb begin
      wr = (op >= 5'd5 && op <= 5'd9) || (op >= 5'd11 && op <= 5'd16) || (op >= 5'd18 && op <= 5'd21);
      ill = (op == 5'd17) || (op >= 5'd22);
      tk = (op == 5'd1 && o_nzp[1]) || (op == 5'd2 && |o_nzp[1:0]) ||
           (op == 5'd3 && (o_nzp[2] | o_nzp[0])) || (op == 5'd4 && |o_nzp[2:1]) ||
           op == 5'd8 || op == 5'd10;
      tgt = (op == 5'd10) ? i_r1data[IADDR:0] : i_result[IADDR:0];
      state_n = state;
      cnt_n = cnt;
      if (run_acc && tk) begin
         state_n = FLUSH;
         cnt_n = 3'(FLUSH_CNT);
      end else if (acc && state == FLUSH) begin
         cnt_n = cnt - 3'd1;
         state_n = (cnt == 3'd1) ? RUN : FLUSH;
      end
   end
   // squash FSM state and counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RUN;
         cnt <= 3'd0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
      end
   end
   // registered outputs; payloads only load when their strobe fires
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_carry <= 1'b0;
         o_nzp <= 3'b010;
         o_we <= 1'b0;
         o_wsel <= '0;
         o_wdata <= '0;
         o_br_taken <= 1'b0;
         o_br_target <= '0;
         o_illegal <= 1'b0;
      end else begin
         o_we <= run_acc & wr;
         o_br_taken <= run_acc & tk;
         o_illegal <= run_acc & ill;
         if (run_acc & wr) begin
            o_wsel <= rd;
            o_wdata <= i_result;
            o_nzp <= {n, z, ~n & ~z};
         end
         if (run_acc & tk) o_br_target <= tgt;
         if (run_acc && op == 5'd20) o_carry <= z_r1();
         else if (run_acc && op == 5'd21) o_carry <= o_carry & z_r1();
      end
   end
   function automatic logic z_r1();
      return ~|i_r1data;
   endfunction
endmodule

// File: tb/tb_lc4_wb_stage.sv
// tb_lc4_wb_stage: random and directed check of lc4_wb_stage against a behavioural model
module tb_lc4_wb_stage;
   localparam int W = 256;
   localparam int FC = 2;
   logic clk = 0, rst_n = 0, i_valid = 0, i_stall = 0;
   logic [19:0] i_insn = '0;
   logic [W-1:0] i_r1data = '0, i_result = '0;
   logic o_carry, o_we, o_br_taken, o_illegal;
   logic [2:0] o_nzp;
   logic [3:0] o_wsel;
   logic [W-1:0] o_wdata;
   logic [10:0] o_br_target;
   int total = 0, bad = 0;
   bit chk_en = 0;
   int m_squash = 0;
   logic m_carry = 0;
   logic [2:0] m_nzp = 3'b010;
   logic e_we = 0, e_tk = 0, e_ill = 0, e_rst = 0;
   logic [3:0] e_wsel = 0;
   logic [W-1:0] e_wdata = 0;
   logic [10:0] e_tgt = 0;
   lc4_wb_stage dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_stall(i_stall), .i_insn(i_insn),
      .i_r1data(i_r1data), .i_result(i_result), .o_carry(o_carry), .o_nzp(o_nzp),
      .o_we(o_we), .o_wsel(o_wsel), .o_wdata(o_wdata), .o_br_taken(o_br_taken),
      .o_br_target(o_br_target), .o_illegal(o_illegal)
   );
   always #5 clk = ~clk;
   task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [19:0] mk(input int op, input int rd);
      logic [4:0] o;
      logic [3:0] r;
      o = 5'(op);
      r = 4'(rd);
      return {o, r, 11'd0};
   endfunction
   function automatic logic [W-1:0] rnd();
      logic [W-1:0] r;
      for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction
   // what the outputs must be after this edge, from the instruction-level rules
   task automatic model_step();
      int op;
      bit tk;
      e_we = 0; e_tk = 0; e_ill = 0; e_rst = 0;
      if (!rst_n) begin
         m_squash = 0; m_carry = 0; m_nzp = 3'b010; e_rst = 1;
         return;
      end
      if (!i_valid || i_stall) return;
      if (m_squash > 0) begin
         m_squash--;
         return;
      end
      op = int'(i_insn[19:15]);
      case (op)
         1: tk = (m_nzp == 3'b010);
         2: tk = (m_nzp != 3'b100);
         3: tk = (m_nzp != 3'b010);
         4: tk = (m_nzp != 3'b001);
         8, 10: tk = 1;
         default: tk = 0;
      endcase
      if (tk) begin
         e_tk = 1;
         e_tgt = (op == 10) ? i_r1data[10:0] : i_result[10:0];
         m_squash = FC;
      end
      if (op inside {[5:9], [11:16], [18:21]}) begin
         e_we = 1; e_wsel = i_insn[14:11]; e_wdata = i_result;
         if (i_result == 0) m_nzp = 3'b010;
         else if (i_result[W-1]) m_nzp = 3'b100;
         else m_nzp = 3'b001;
      end
      e_ill = (op == 17 || op >= 22);
      if (op == 20) m_carry = (i_r1data == 0);
      if (op == 21) m_carry = m_carry && (i_r1data == 0);
   endtask
   task automatic step(input logic v, input logic s, input logic r, input logic [19:0] insn,
                       input logic [W-1:0] r1, input logic [W-1:0] res);
      rst_n = r; i_valid = v; i_stall = s; i_insn = insn; i_r1data = r1; i_result = res;
      @(posedge clk);
      model_step();
      #1;
   endtask
   // compare every cycle against the model
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("we", W'(o_we), W'(e_we));
         cmp("br_taken", W'(o_br_taken), W'(e_tk));
         cmp("illegal", W'(o_illegal), W'(e_ill));
         cmp("nzp", W'(o_nzp), W'(m_nzp));
         cmp("carry", W'(o_carry), W'(m_carry));
         if (e_we) begin
            cmp("wsel", W'(o_wsel), W'(e_wsel));
            cmp("wdata", o_wdata, e_wdata);
         end
         if (e_tk) cmp("br_target", W'(o_br_target), W'(e_tgt));
         if (e_rst) begin
            cmp("rst_wsel", W'(o_wsel), '0);
            cmp("rst_wdata", o_wdata, '0);
            cmp("rst_target", W'(o_br_target), '0);
         end
      end
   end
   task automatic lit(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      @(negedge clk);
      #1;
      cmp(name, act, exp);
   endtask
   initial begin
      logic [W-1:0] neg;
      neg = '0;
      neg[W-1] = 1'b1;
      step(1, 1, 0, mk(8, 0), 0, 0);
      chk_en = 1;
      step(0, 0, 0, 0, 0, 0);
      lit("L_rst_nzp", W'(o_nzp), W'(3'b010));
      step(1, 0, 1, mk(5, 3), 0, 0);
      lit("L_add_we", W'(o_we), 1);
      cmp("L_add_wsel", W'(o_wsel), 3);
      cmp("L_add_nzp", W'(o_nzp), W'(3'b010));
      step(1, 0, 1, mk(6, 2), 0, neg | 5);
      lit("L_sub_nzp", W'(o_nzp), W'(3'b100));
      step(1, 0, 1, mk(3, 0), 0, W'(12'h155));
      lit("L_brnp_tk", W'(o_br_taken), 1);
      cmp("L_brnp_tgt", W'(o_br_target), W'(12'h155));
      step(1, 0, 1, mk(5, 1), 0, 7);
      lit("L_sq1_we", W'(o_we), 0);
      step(0, 0, 1, mk(5, 1), 0, 7);
      step(1, 0, 1, mk(5, 1), 0, 7);
      lit("L_sq2_we", W'(o_we), 0);
      step(1, 0, 1, mk(5, 1), 0, 7);
      lit("L_add3_we", W'(o_we), 1);
      cmp("L_add3_nzp", W'(o_nzp), W'(3'b001));
      step(1, 0, 1, mk(20, 0), 0, 9);
      lit("L_tcs", W'(o_carry), 1);
      step(1, 0, 1, mk(21, 0), 5, 9);
      lit("L_tcdh5", W'(o_carry), 0);
      step(1, 0, 1, mk(21, 0), 0, 9);
      lit("L_tcdh0", W'(o_carry), 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 1, mk(8, 7), 0, W'(12'h0AA));
         lit("L_jsr_stall", W'(o_br_taken), 0);
      end
      step(1, 0, 1, mk(8, 7), 0, W'(12'h0AA));
      lit("L_jsr_tk", W'(o_br_taken), 1);
      step(1, 1, 1, mk(5, 1), 0, 7);
      step(1, 0, 1, mk(5, 1), 0, 7);
      step(1, 0, 1, mk(5, 1), 0, 7);
      lit("L_jsr_sq_we", W'(o_we), 0);
      step(1, 0, 1, mk(5, 1), 0, 7);
      lit("L_jsr_after_we", W'(o_we), 1);
      step(1, 0, 1, mk(24, 0), 1, 0);
      lit("L_ill", W'(o_illegal), 1);
      cmp("L_ill_nzp", W'(o_nzp), W'(3'b001));
      step(1, 0, 1, mk(5, 4), 0, 0);
      step(1, 0, 1, mk(1, 0), 0, 3);
      lit("L_brz_tk", W'(o_br_taken), 1);
      step(1, 0, 0, mk(5, 4), 0, 1);
      step(1, 0, 1, mk(5, 4), 0, 1);
      lit("L_rst_flush_we", W'(o_we), 1);
      for (int i = 0; i < 4000; i++) begin
         logic [W-1:0] res, r1;
         int m;
         m = int'($urandom_range(0, 3));
         res = (m == 0) ? '0 : (m == 1) ? (rnd() | neg) : (rnd() & ~neg);
         r1 = ($urandom_range(0, 2) == 0) ? '0 : rnd();
         step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 63) != 0,
              mk(int'($urandom_range(0, 31)), int'($urandom_range(0, 15))), r1, res);
      end
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lc4_wb_stage.md
LC4_WB_STAGE -- requirements
Module: lc4_wb_stage

Interface
REQ-001 Parameter WORD_SIZE, default 256, datapath width.
REQ-002 Parameter INSN, default 19, MSB index of instruction word.
REQ-003 Parameter IADDR, default 10, MSB index of PC/branch target.
REQ-004 Parameter FLUSH_CNT, default 2, number of accepted instructions squashed after a taken redirect; legal range 1-7.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 i_valid  in  1  execute-stage instruction present this cycle.
REQ-008 i_stall  in  1  hold: the input is ignored and all state is held.
REQ-009 i_insn  in  INSN+1  instruction; opcode [19:15], rd [14:11].
REQ-010 i_r1data  in  WORD_SIZE  rs operand as presented to the ALU.
REQ-011 i_result  in  WORD_SIZE  ALU result for i_insn.
REQ-012 o_carry  out  1  carry flag, fed back to ALU carry input.
REQ-013 o_nzp  out  3  condition codes {N,Z,P}.
REQ-014 o_we, o_wsel[3:0], o_wdata[WORD_SIZE-1:0]  out  register-file write port.
REQ-015 o_br_taken  out  1  one-cycle redirect pulse; o_br_target[IADDR:0] out, redirect PC.
REQ-016 o_illegal  out  1  one-cycle pulse on an accepted undefined opcode.

Function
REQ-017 An instruction is accepted when i_valid=1, i_stall=0, rst_n=1; all outputs are registered, with latency 1 cycle from acceptance.
REQ-018 FSM states: RUN and FLUSH; a 3-bit squash counter is loaded with FLUSH_CNT on entry to FLUSH.
REQ-019 In FLUSH, each accepted instruction decrements the counter, produces no write, redirect, flag or illegal effect; counter 1->0 returns to RUN on the same edge.
REQ-020 Write class (RUN): opcodes 00101-01001, 01011-10000, 10010-10101 -> o_we=1, o_wsel=rd, o_wdata=i_result.
REQ-021 On a write, NZP is set to: N=i_result[WORD_SIZE-1]; Z=(i_result==0); P=!N&!Z; exactly one bit is set.
REQ-022 TCS (10100): o_carry <= (i_r1data==0).
REQ-023 TCDH (10101): o_carry <= o_carry & (i_r1data==0).
REQ-024 All other opcodes leave o_carry unchanged.
REQ-025 Branch conditions: BRz 00001 taken if Z; BRzp 00010 if Z|P; BRnp 00011 if N|P; BRnz 00100 if N|Z; JSR 01000 always; NOP 00000 never.
REQ-026 Branch evaluation uses the NZP value held before this instruction; branch opcodes never write and never change flags.
REQ-027 Branch target = i_result[IADDR:0].
REQ-028 RTI (01010): always taken, target i_r1data[IADDR:0], no write.
REQ-029 A taken branch, JSR or RTI pulses o_br_taken with o_br_target and enters FLUSH on the same edge.
REQ-030 Opcodes 10001 and 10110-11111: o_illegal pulse, no write, no flag change, no redirect.
REQ-031 o_we, o_br_taken and o_illegal are 0 in any cycle following a non-accepting edge (i_valid=0 or i_stall=1).
REQ-032 o_wsel, o_wdata and o_br_target are don't-care when their strobe is low.
REQ-033 Under stall, FSM, counter, NZP and carry all hold.
REQ-034 Stall and an invalid cycle in FLUSH do not decrement the counter.

Reset
REQ-035 When rst_n=0 at a rising edge: state=RUN, counter=0, o_carry=0, o_nzp=3'b010, o_we=0, o_br_taken=0, o_illegal=0, o_wsel=0, o_wdata=0, o_br_target=0.
REQ-036 Reset overrides i_valid and i_stall; reset during FLUSH abandons the squash.
REQ-037 The first instruction accepted after reset is processed in RUN.

Verification
REQ-038 Reset, then ADD rd=3, result=0 -> next cycle o_we=1, o_wsel=3, o_wdata=0, o_nzp=010.
REQ-039 SUB with result MSB=1, then BRnp target 0x155 -> o_nzp=100; o_br_taken=1, o_br_target=0x155; the next 2 accepted ADDs produce no write; the third ADD writes.
REQ-040 TCS with r1=0 -> o_carry=1; then TCDH r1=5 -> o_carry=0; then TCDH r1=0 -> o_carry stays 0.
REQ-041 JSR with i_stall=1 for 3 cycles, then released -> no effect while stalled; a single o_br_taken pulse one cycle after release; flush counter intact.
REQ-042 Opcode 11000 -> o_illegal pulse, nzp/carry unchanged; rst_n=0 mid-FLUSH, then ADD -> ADD writes.
